// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a FIFO: 8N1-style framing with configurable data bits, parity and stop bits.
// Optional line-break generation is compiled in with `define UART_TX_BREAK_EN (adds input brk).
module uart_tx_fifo #(
    parameter int    DATA_BITS  = 8,
    parameter string PARITY     = "NONE",
    parameter int    STOP_BITS  = 1,
    parameter int    FIFO_DEPTH = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               tx_bd_en,
    input  logic                               wr_en,
    input  logic [DATA_BITS-1:0]               wr_data,
`ifdef UART_TX_BREAK_EN
    input  logic                               brk,
`endif
    output logic                               full,
    output logic                               empty,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    level,
    output logic                               busy,
    output logic                               tx,
    output logic                               ovf
);

    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int LW      = $clog2(FIFO_DEPTH + 1);
    localparam int CW      = $clog2(DATA_BITS);
    localparam bit PAR_EN  = (PARITY != "NONE");
    localparam bit PAR_ODD = (PARITY == "ODD");

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP
    } state_t;

    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]        r_wr_ptr;
    logic [AW-1:0]        r_rd_ptr;
    logic [LW-1:0]        r_level;
    logic                 r_ovf;

    state_t               r_state;
    logic [DATA_BITS-1:0] r_shift;
    logic [CW-1:0]        r_bit_cnt;
    logic                 r_stop_cnt;
    logic                 r_parity;
    logic                 r_tx;
    logic                 r_busy;
`ifdef UART_TX_BREAK_EN
    logic                 r_brk_rec;
`endif

    logic                 w_push;
    logic                 w_pop;
    logic                 w_last_stop;
    logic [DATA_BITS-1:0] w_head;

    assign full        = (r_level == LW'(FIFO_DEPTH));
    assign empty       = (r_level == '0);
    assign level       = r_level;
    assign ovf         = r_ovf;
    assign tx          = r_tx;
    assign busy        = r_busy;

    assign w_push      = wr_en && !full;
    assign w_head      = r_mem[r_rd_ptr];
    assign w_last_stop = (STOP_BITS == 1) || r_stop_cnt;

    // A pop happens exactly when a frame starts, either from IDLE or back-to-back out of STOP.
    always_comb begin
        // NOTE: default first so every path assigns w_pop and no latch is inferred.
        w_pop = 1'b0;
        if (tx_bd_en && !empty) begin
            case (r_state)
`ifdef UART_TX_BREAK_EN
                S_IDLE:  w_pop = !brk && !r_brk_rec;
                S_STOP:  w_pop = w_last_stop && !brk;
`else
                S_IDLE:  w_pop = 1'b1;
                S_STOP:  w_pop = w_last_stop;
`endif
                default: w_pop = 1'b0;
            endcase
        end
    end

    // NOTE: storage array carries no reset; pointers and level define which entries are valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            r_ovf <= wr_en && full;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
            r_parity   <= 1'b0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
`ifdef UART_TX_BREAK_EN
            r_brk_rec  <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
`ifdef UART_TX_BREAK_EN
                    // Break ends on a bit boundary, then one full idle-high period precedes START.
                    if (brk) begin
                        r_tx      <= 1'b0;
                        r_brk_rec <= 1'b1;
                    end else if (r_brk_rec) begin
                        if (tx_bd_en) begin
                            r_tx      <= 1'b1;
                            r_brk_rec <= 1'b0;
                        end
                    end else
`endif
                    if (w_pop) begin
                        r_shift  <= w_head;
                        r_parity <= (^w_head) ^ PAR_ODD;
                        r_tx     <= 1'b0;
                        r_busy   <= 1'b1;
                        r_state  <= S_START;
                    end
                end
                S_START: begin
                    if (tx_bd_en) begin
                        r_tx      <= r_shift[0];
                        r_shift   <= r_shift >> 1;
                        r_bit_cnt <= '0;
                        r_state   <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (tx_bd_en) begin
                        if (r_bit_cnt == CW'(DATA_BITS - 1)) begin
                            if (PAR_EN) begin
                                r_tx    <= r_parity;
                                r_state <= S_PAR;
                            end else begin
                                r_tx       <= 1'b1;
                                r_stop_cnt <= 1'b0;
                                r_state    <= S_STOP;
                            end
                        end else begin
                            r_tx      <= r_shift[0];
                            r_shift   <= r_shift >> 1;
                            r_bit_cnt <= r_bit_cnt + CW'(1);
                        end
                    end
                end
                S_PAR: begin
                    if (tx_bd_en) begin
                        r_tx       <= 1'b1;
                        r_stop_cnt <= 1'b0;
                        r_state    <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (tx_bd_en) begin
                        if (!w_last_stop) begin
                            r_stop_cnt <= 1'b1;
                        end else if (w_pop) begin
                            r_shift  <= w_head;
                            r_parity <= (^w_head) ^ PAR_ODD;
                            r_tx     <= 1'b0;
                            r_state  <= S_START;
                        end else begin
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: framing (8N1, even/odd parity, 2 stop bits), FIFO full/overflow,
// push+pop on full, back-to-back frames and mid-frame reset, each against hand-derived values.
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic       tx_bd_en;
    logic [7:0] wr_data;
    logic       brk = 1'b0;

    logic       wr_en_a, full_a, empty_a, busy_a, tx_a, ovf_a;
    logic [4:0] level_a;
    logic       wr_en_e, full_e, empty_e, busy_e, tx_e, ovf_e;
    logic [4:0] level_e;
    logic       wr_en_o, full_o, empty_o, busy_o, tx_o, ovf_o;
    logic [4:0] level_o;
    logic       wr_en_d, full_d, empty_d, busy_d, tx_d, ovf_d;
    logic [2:0] level_d;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    uart_tx_fifo u_def (
        .clk(clk), .rst(rst), .tx_bd_en(tx_bd_en), .wr_en(wr_en_a), .wr_data(wr_data),
`ifdef UART_TX_BREAK_EN
        .brk(brk),
`endif
        .full(full_a), .empty(empty_a), .level(level_a), .busy(busy_a), .tx(tx_a), .ovf(ovf_a)
    );

    uart_tx_fifo #(.PARITY("EVEN")) u_even (
        .clk(clk), .rst(rst), .tx_bd_en(tx_bd_en), .wr_en(wr_en_e), .wr_data(wr_data),
`ifdef UART_TX_BREAK_EN
        .brk(brk),
`endif
        .full(full_e), .empty(empty_e), .level(level_e), .busy(busy_e), .tx(tx_e), .ovf(ovf_e)
    );

    uart_tx_fifo #(.PARITY("ODD"), .STOP_BITS(2)) u_odd (
        .clk(clk), .rst(rst), .tx_bd_en(tx_bd_en), .wr_en(wr_en_o), .wr_data(wr_data),
`ifdef UART_TX_BREAK_EN
        .brk(brk),
`endif
        .full(full_o), .empty(empty_o), .level(level_o), .busy(busy_o), .tx(tx_o), .ovf(ovf_o)
    );

    uart_tx_fifo #(.FIFO_DEPTH(4)) u_d4 (
        .clk(clk), .rst(rst), .tx_bd_en(tx_bd_en), .wr_en(wr_en_d), .wr_data(wr_data),
`ifdef UART_TX_BREAK_EN
        .brk(brk),
`endif
        .full(full_d), .empty(empty_d), .level(level_d), .busy(busy_d), .tx(tx_d), .ovf(ovf_d)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Outputs are sampled 1 time unit after the rising edge; inputs change at the same point.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe();
        tx_bd_en = 1'b1;
        tick();
        tx_bd_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [0:12] exp_tx_a, exp_tx_e, exp_tx_o;
        logic [0:12] exp_bsy_a, exp_bsy_e, exp_bsy_o;
        logic [7:0]  words [5];
        logic [7:0]  w;
        int          stream [$];

        rst = 1'b1; tx_bd_en = 1'b0; wr_data = 8'h00;
        wr_en_a = 1'b0; wr_en_e = 1'b0; wr_en_o = 1'b0; wr_en_d = 1'b0;
        tick(); tick();

        check("rst_tx",    tx_a,    1);
        check("rst_full",  full_a,  0);
        check("rst_empty", empty_a, 1);
        check("rst_level", level_a, 0);
        check("rst_busy",  busy_a,  0);
        check("rst_ovf",   ovf_a,   0);
        check("rst_tx_d",  tx_d,    1);
        check("rst_lvl_d", level_d, 0);
        rst = 1'b0;
        tick();

        // Frame tests: 0x66 on 8N1, 0x07 on 8E1 and 8O2, all started on the same strobe.
        wr_data = 8'h66; wr_en_a = 1'b1;
        tick();
        wr_en_a = 1'b0;
        check("push_level", level_a, 1);
        check("push_empty", empty_a, 0);
        wr_data = 8'h07; wr_en_e = 1'b1; wr_en_o = 1'b1;
        tick();
        wr_en_e = 1'b0; wr_en_o = 1'b0;

        exp_tx_a  = 13'b0011001101111;
        exp_tx_e  = 13'b0111000001111;
        exp_tx_o  = 13'b0111000000111;
        exp_bsy_a = 13'b1111111111000;
        exp_bsy_e = 13'b1111111111100;
        exp_bsy_o = 13'b1111111111110;
        for (int k = 0; k < 13; k++) begin
            strobe();
            check($sformatf("n81_tx[%0d]", k), tx_a, exp_tx_a[k]);
            check($sformatf("n81_busy[%0d]", k), busy_a, exp_bsy_a[k]);
            check($sformatf("e81_tx[%0d]", k), tx_e, exp_tx_e[k]);
            check($sformatf("e81_busy[%0d]", k), busy_e, exp_bsy_e[k]);
            check($sformatf("o82_tx[%0d]", k), tx_o, exp_tx_o[k]);
            check($sformatf("o82_busy[%0d]", k), busy_o, exp_bsy_o[k]);
            if (k == 0) check("pop_level", level_a, 0);
            repeat (7) tick();
            check($sformatf("n81_hold[%0d]", k), tx_a, exp_tx_a[k]);
        end

        // Depth-4 FIFO: fill, overflow, then push+pop on a full FIFO.
        words[0] = 8'hA1; words[1] = 8'hB2; words[2] = 8'hC3; words[3] = 8'hD4; words[4] = 8'h5A;
        for (int i = 0; i < 4; i++) begin
            wr_data = words[i]; wr_en_d = 1'b1;
            tick();
            check($sformatf("fill_level[%0d]", i), level_d, i + 1);
            check($sformatf("fill_full[%0d]", i), full_d, (i == 3) ? 1 : 0);
        end
        wr_data = 8'hE5;
        tick();
        wr_en_d = 1'b0;
        check("ovf_pulse", ovf_d, 1);
        check("ovf_level", level_d, 4);
        check("ovf_full",  full_d, 1);
        tick();
        check("ovf_clear", ovf_d, 0);

        wr_data = 8'hF6; wr_en_d = 1'b1;
        strobe();
        wr_en_d = 1'b0;
        check("pushpop_ovf",   ovf_d, 1);
        check("pushpop_level", level_d, 3);
        check("pushpop_full",  full_d, 0);

        for (int i = 0; i < 5; i++) begin
            w = words[i];
            stream.push_back(0);
            for (int b = 0; b < 8; b++) stream.push_back(int'(w[b]));
            stream.push_back(1);
        end
        repeat (2) stream.push_back(1);

        check("d4_tx[0]", tx_d, stream[0]);
        repeat (7) tick();
        for (int k = 1; k < 52; k++) begin
            strobe();
            check($sformatf("d4_tx[%0d]", k), tx_d, stream[k]);
            check($sformatf("d4_busy[%0d]", k), busy_d, (k < 50) ? 1 : 0);
            if (k == 3) begin
                wr_data = words[4]; wr_en_d = 1'b1;
                tick();
                wr_en_d = 1'b0;
                check("inflight_push_level", level_d, 4);
                repeat (6) tick();
            end else begin
                repeat (7) tick();
            end
        end
        check("d4_drained", empty_d, 1);

        // Reset during the 4th data bit of 0x11 with three words still queued.
        for (int i = 0; i < 4; i++) begin
            wr_data = 8'h11 * (i + 1); wr_en_d = 1'b1;
            tick();
        end
        wr_en_d = 1'b0;
        for (int k = 0; k < 5; k++) begin
            strobe();
            repeat ((k == 4) ? 3 : 7) tick();
        end
        check("mid_tx_bit3", tx_d, 0);
        check("mid_level",   level_d, 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_tx",    tx_d, 1);
        check("midrst_level", level_d, 0);
        check("midrst_empty", empty_d, 1);
        check("midrst_busy",  busy_d, 0);
        for (int k = 0; k < 12; k++) begin
            strobe();
            check($sformatf("postrst_tx[%0d]", k), tx_d, 1);
            check($sformatf("postrst_busy[%0d]", k), busy_d, 0);
            repeat (7) tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
